// File: rtl/onehot_scan_encoder.sv
// Sequential one-hot/bitmap encoder: accepts a WIDTH-bit vector and streams the
// index of every set bit, lowest first, one index per output handshake.
module onehot_scan_encoder #(
  parameter int WIDTH = 8,
  parameter int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic [IDX_W:0]   out_count
);

  typedef enum logic {
    IDLE,
    SCAN
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pending_q, pending_d;
  logic             zero_q, zero_d;
  logic [IDX_W:0]   count_q, count_d;

  logic [IDX_W-1:0] lowIdx;
  logic [IDX_W:0]   vecCount;
  logic             atMostOne;
  logic             inAccept;
  logic             outAccept;

  // Priority search from the top down so the lowest set bit wins.
  always_comb begin
    lowIdx = '0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      if (pending_q[i]) lowIdx = IDX_W'(i);
    end
  end

  always_comb begin
    vecCount = '0;
    for (int i = 0; i < WIDTH; i++) begin
      vecCount = vecCount + {{IDX_W{1'b0}}, in_vec[i]};
    end
  end

  // Clearing the lowest set bit leaves zero exactly when at most one bit is set.
  assign atMostOne = ((pending_q & (pending_q - WIDTH'(1))) == '0);

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == SCAN);
  assign out_idx   = lowIdx;
  assign out_last  = (state_q == SCAN) && atMostOne;
  assign out_none  = zero_q;
  assign out_count = count_q;

  assign inAccept  = in_valid && in_ready;
  assign outAccept = out_valid && out_ready;

  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    zero_d    = zero_q;
    count_d   = count_q;
    unique case (state_q)
      IDLE: begin
        if (inAccept) begin
          state_d   = SCAN;
          pending_d = in_vec;
          zero_d    = (in_vec == '0);
          count_d   = vecCount;
        end
      end
      SCAN: begin
        if (outAccept) begin
          pending_d = pending_q & ~(WIDTH'(1) << lowIdx);
          if (atMostOne) begin
            state_d = IDLE;
            zero_d  = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      pending_q <= '0;
      zero_q    <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      zero_q    <= zero_d;
      count_q   <= count_d;
    end
  end

endmodule

// File: tb/tb_onehot_scan_encoder.sv
// Scoreboard bench for onehot_scan_encoder: expected beats are queued when a
// vector is driven and compared as the encoder presents them.
module tb_onehot_scan_encoder;

  logic       clk;
  logic       rst_n;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_vec;
  logic       out_valid;
  logic       out_ready;
  logic [2:0] out_idx;
  logic       out_last;
  logic       out_none;
  logic [3:0] out_count;

  typedef struct packed {
    logic [2:0] idx;
    logic       last;
    logic       none;
    logic [3:0] count;
  } beat_t;

  beat_t sbQ[$];
  int    checksTotal;
  int    checksPassed;

  onehot_scan_encoder #(.WIDTH(8), .IDX_W(3)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_vec   (in_vec),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_idx  (out_idx),
    .out_last (out_last),
    .out_none (out_none),
    .out_count(out_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checksTotal++;
    if (got !== exp)
      $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, exp);
    else
      checksPassed++;
  endtask

  // Drive one vector once the encoder is idle and queue the beats it should produce.
  task automatic applyStimulus(input logic [7:0] vec);
    int         waitCycles;
    logic [3:0] cnt;
    logic [3:0] remaining;
    beat_t      b;
    waitCycles = 0;
    @(negedge clk);
    while (!in_ready && waitCycles < 40) begin
      @(negedge clk);
      waitCycles++;
    end
    if (!in_ready) checkOutput("in_ready_timeout", 32'(in_ready), 32'd1);
    in_valid = 1'b1;
    in_vec   = vec;
    cnt = '0;
    for (int i = 0; i < 8; i++) if (vec[i]) cnt = cnt + 4'd1;
    if (vec == 8'h00) begin
      b = '{idx: 3'd0, last: 1'b1, none: 1'b1, count: 4'd0};
      sbQ.push_back(b);
    end else begin
      remaining = cnt;
      for (int i = 0; i < 8; i++) begin
        if (vec[i]) begin
          remaining = remaining - 4'd1;
          b = '{idx: 3'(i), last: (remaining == 4'd0), none: 1'b0, count: cnt};
          sbQ.push_back(b);
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_vec   = 8'($urandom);
  endtask

  task automatic compareFront(input string tag);
    beat_t b;
    b = sbQ[0];
    checkOutput({tag, "_valid"}, 32'(out_valid), 32'd1);
    checkOutput({tag, "_idx"},   32'(out_idx),   32'(b.idx));
    checkOutput({tag, "_last"},  32'(out_last),  32'(b.last));
    checkOutput({tag, "_none"},  32'(out_none),  32'(b.none));
    checkOutput({tag, "_count"}, 32'(out_count), 32'(b.count));
  endtask

  // Consume queued beats, optionally stalling out_ready before beat stallBeat.
  task automatic drainBeats(input string tag, input int stallBeat, input int stallLen);
    int beatNo;
    int stalled;
    int cycles;
    beatNo  = 0;
    stalled = 0;
    cycles  = 0;
    while (sbQ.size() > 0 && cycles < 60) begin
      @(negedge clk);
      cycles++;
      compareFront(tag);
      if (beatNo == stallBeat && stalled < stallLen) begin
        out_ready = 1'b0;
        stalled++;
      end else begin
        out_ready = 1'b1;
        if (out_valid) begin
          void'(sbQ.pop_front());
          beatNo++;
        end
      end
    end
    if (sbQ.size() > 0) begin
      checkOutput({tag, "_drain_timeout"}, 32'(sbQ.size()), 32'd0);
      sbQ.delete();
    end
    @(negedge clk);
    checkOutput({tag, "_done_valid"}, 32'(out_valid), 32'd0);
    checkOutput({tag, "_done_ready"}, 32'(in_ready), 32'd1);
    out_ready = 1'b1;
  endtask

  initial begin
    checksTotal  = 0;
    checksPassed = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    in_vec    = '0;
    out_ready = 1'b1;

    #12;
    checkOutput("rst_valid", 32'(out_valid), 32'd0);
    checkOutput("rst_ready", 32'(in_ready),  32'd1);
    checkOutput("rst_idx",   32'(out_idx),   32'd0);
    checkOutput("rst_last",  32'(out_last),  32'd0);
    checkOutput("rst_none",  32'(out_none),  32'd0);
    checkOutput("rst_count", 32'(out_count), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    applyStimulus(8'b0010_0000);
    drainBeats("single", -1, 0);

    applyStimulus(8'b1001_0010);
    drainBeats("three", -1, 0);

    applyStimulus(8'b1001_0010);
    drainBeats("stall", 1, 3);

    applyStimulus(8'h00);
    drainBeats("zero", -1, 0);

    applyStimulus(8'hFF);
    drainBeats("ones", -1, 0);

    // Reset in the middle of a scan, right after the idx=4 beat is taken.
    applyStimulus(8'hF0);
    @(negedge clk);
    compareFront("midrst");
    out_ready = 1'b1;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midrst_valid", 32'(out_valid), 32'd0);
    checkOutput("midrst_ready", 32'(in_ready),  32'd1);
    checkOutput("midrst_count", 32'(out_count), 32'd0);
    checkOutput("midrst_idx",   32'(out_idx),   32'd0);
    checkOutput("midrst_last",  32'(out_last),  32'd0);
    sbQ.delete();
    in_valid = 1'b1;
    in_vec   = 8'hAA;
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    checkOutput("inrst_noaccept", 32'(out_valid), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (3) begin
      @(negedge clk);
      checkOutput("postrst_valid", 32'(out_valid), 32'd0);
      checkOutput("postrst_ready", 32'(in_ready),  32'd1);
    end

    // Decoder loopback: each one-hot vector returns its decoder input in one beat.
    for (int k = 0; k < 8; k++) begin
      logic [7:0] dec;
      dec = 8'd1 << k;
      applyStimulus(dec);
      drainBeats("loop", -1, 0);
    end

    $display("[TB] %0d/%0d checks passed", checksPassed, checksTotal);
    $finish;
  end

endmodule

// File: doc/onehot_scan_encoder.md
Name: onehot_scan_encoder

Overview:
- Sequential inverse of the team's 3-to-8 one-hot decoder.
- Accepts an 8-bit bit-vector, then emits the 3-bit index of every set bit, one index per output handshake, lowest index first.
- A one-hot input round-trips through the decoder in a single beat (decoder in=k gives vector bit k, which this block returns as idx=k).
- Used to serialise request/flag bitmaps into index streams for downstream logic.

Parameters:
- WIDTH, 8: input vector width; must be a power of 2, at least 2.
- IDX_W, 3: index width, equal to $clog2(WIDTH); set consistently with WIDTH.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- in_valid  input  1  in_vec is valid
- in_ready  output  1  block can accept a vector
- in_vec  input  WIDTH  bitmap to encode
- out_valid  output  1  out_idx/out_last/out_none are valid
- out_ready  input  1  consumer accepts the current beat
- out_idx  output  IDX_W  index of the lowest remaining set bit
- out_last  output  1  current beat is the final beat for this vector
- out_none  output  1  accepted vector was all zeros (single-beat marker)
- out_count  output  IDX_W+1  popcount of the accepted vector, held for the whole scan

Behaviour:
- One clock (clk). Reset is asynchronous and active-low (rst_n). All state is in flops on clk rising edge.
- Reset (rst_n low, takes effect immediately):
  - state=IDLE, pending=0, zero_flag=0.
  - out_valid=0, out_idx=0, out_last=0, out_none=0, out_count=0.
  - in_ready=1 (IDLE), but no input is accepted while rst_n is low.
- States:
  - IDLE: in_ready=1, out_valid=0.
  - SCAN: in_ready=0, out_valid=1.
- IDLE to SCAN: on in_valid && in_ready at an edge:
  - pending <= in_vec.
  - out_count <= popcount(in_vec).
  - zero_flag <= (in_vec==0).
- Latency: out_valid is high in the cycle after acceptance.
- In SCAN, the outputs are pure functions of the registered state:
  - out_idx = index of the lowest set bit of pending; 0 if pending==0.
  - out_last = (pending has at most one bit set).
  - out_none = zero_flag.
- Beat transfer (out_valid && out_ready at an edge):
  - Clear the bit at out_idx in pending.
  - If out_last, go to IDLE and clear zero_flag.
- Backpressure: while out_ready=0, out_idx, out_last, out_none and out_count hold stable. in_vec changes during SCAN are ignored.
- Zero vector: exactly one beat with out_idx=0, out_none=1, out_last=1, out_count=0.
- All-ones vector: WIDTH beats, idx 0..WIDTH-1; out_last only on idx WIDTH-1; out_count=WIDTH (hence the IDX_W+1 width).
- No overlap: the next vector is accepted no earlier than the cycle after the last beat's handshake. Throughput is max(popcount,1)+1 cycles per vector when out_ready is held high.
- out_count holds its value in IDLE until the next acceptance.
- Reset mid-scan: the scan is abandoned, remaining beats are discarded, and all outputs return to reset values asynchronously.

Test Plan:
- Reset then in_vec=8'b0010_0000 with out_ready=1:
  - Accept, then one cycle later out_valid=1, idx=5, last=1, none=0, count=1.
  - Next cycle in_ready=1.
- in_vec=8'b1001_0010 with out_ready=1:
  - Beats idx=1, 4, 7 on consecutive cycles; last=1 only on 7; count=3 throughout.
- Same vector with out_ready low for 3 cycles at the second beat:
  - idx=4, last=0 held stable for 3 cycles; no beat lost or duplicated.
- in_vec=8'h00:
  - One beat, idx=0, none=1, last=1, count=0, then IDLE.
- in_vec=8'hFF:
  - Eight beats idx 0..7, count=8, last on 7.
  - Then pull rst_n low during a new 8'hF0 scan after beat idx=4: out_valid drops immediately, and after release in_ready=1 with no stale beats.
- Loopback: feed 3-to-8 decoder output for in=0..7:
  - Each yields exactly one beat with idx equal to the decoder input and last=1.
